// File: rtl/note_estimator.sv
// note_estimator
// Converts a measured signal period (in 1.024 MHz clk cycles) into the
// nearest open-string guitar note and a signed tuning deviation in per-mille.
// The conversion takes 33 clock cycles after capture. It uses a multi-cycle
// boundary scan, a shift-add multiply and a restoring divide.
//
// Ports:
//   clk            in   system clock
//   rst            in   asynchronous active-high reset
//   period_cycles  in   measured period (PW bits), sampled on period_valid
//   period_valid   in   one-cycle capture strobe (ignored while busy)
//   busy           out  high while a conversion is in progress
//   note           out  0..5 = E2,A2,D3,G3,B3,E4; 7 = no note / out of range
//   num_to_display out  signed deviation, per-mille, clamped to -511..+511
//   result_valid   out  one-cycle pulse when note/num_to_display update
module note_estimator #(
  parameter int unsigned PW         = 20,
  parameter int unsigned REF_E2     = 12426,
  parameter int unsigned REF_A2     = 9309,
  parameter int unsigned REF_D3     = 6974,
  parameter int unsigned REF_G3     = 5224,
  parameter int unsigned REF_B3     = 4147,
  parameter int unsigned REF_E4     = 3107,
  parameter int unsigned BND0       = 10755,
  parameter int unsigned BND1       = 8057,
  parameter int unsigned BND2       = 6036,
  parameter int unsigned BND3       = 4654,
  parameter int unsigned BND4       = 3590,
  parameter int unsigned MIN_PERIOD = 2000,
  parameter int unsigned MAX_PERIOD = 20000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [PW-1:0] period_cycles,
  input  logic          period_valid,
  output logic          busy,
  output logic [2:0]    note,
  output logic [9:0]    num_to_display,
  output logic          result_valid
);

  localparam int unsigned DW = 25;  // dividend / quotient width
  localparam int unsigned RW = 15;  // remainder width (divisor < 2^15)

  typedef enum logic [2:0] {IDLE, SCAN, SUB, MUL, DIV, DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   p_q, p_d;
  logic [2:0]      sel_q, sel_d;
  logic            found_q, found_d;
  logic            oor_q, oor_d;
  logic [4:0]      cnt_q, cnt_d;
  logic            neg_q, neg_d;
  logic [PW-1:0]   mag_q, mag_d;
  logic [RW-1:0]   rem_q, rem_d;
  logic [DW-1:0]   quo_q, quo_d;
  logic            busy_q, busy_d;
  logic [2:0]      note_q, note_d;
  logic [9:0]      num_q, num_d;
  logic            rv_q, rv_d;

  logic [PW-1:0]   ref_sel;
  logic [RW:0]     divisor;
  logic [RW:0]     trial;
  logic [DW-1:0]   mag_ext;
  logic [8:0]      q_clamp;
  logic [9:0]      q_ext;

  function automatic logic [PW-1:0] ref_of(input logic [2:0] s);
    case (s)
      3'd0:    ref_of = PW'(REF_E2);
      3'd1:    ref_of = PW'(REF_A2);
      3'd2:    ref_of = PW'(REF_D3);
      3'd3:    ref_of = PW'(REF_G3);
      3'd4:    ref_of = PW'(REF_B3);
      default: ref_of = PW'(REF_E4);
    endcase
  endfunction

  function automatic logic [PW-1:0] bnd_of(input logic [2:0] i);
    case (i)
      3'd0:    bnd_of = PW'(BND0);
      3'd1:    bnd_of = PW'(BND1);
      3'd2:    bnd_of = PW'(BND2);
      3'd3:    bnd_of = PW'(BND3);
      default: bnd_of = PW'(BND4);
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      sel_q   <= '0;
      found_q <= 1'b0;
      oor_q   <= 1'b0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      mag_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      busy_q  <= 1'b0;
      note_q  <= 3'd7;
      num_q   <= '0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      sel_q   <= sel_d;
      found_q <= found_d;
      oor_q   <= oor_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      mag_q   <= mag_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      busy_q  <= busy_d;
      note_q  <= note_d;
      num_q   <= num_d;
      rv_q    <= rv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    sel_d   = sel_q;
    found_d = found_q;
    oor_d   = oor_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    mag_d   = mag_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    busy_d  = busy_q;
    note_d  = note_q;
    num_d   = num_q;
    rv_d    = 1'b0;

    ref_sel = ref_of(sel_q);
    divisor = (RW+1)'(ref_sel);
    trial   = {rem_q, quo_q[DW-1]};
    mag_ext = DW'(mag_q);
    q_clamp = (quo_q > DW'(511)) ? 9'd511 : quo_q[8:0];
    q_ext   = {1'b0, q_clamp};

    case (state_q)
      IDLE: begin
        if (period_valid) begin
          p_d     = period_cycles;
          sel_d   = 3'd5;
          found_d = 1'b0;
          oor_d   = (period_cycles < PW'(MIN_PERIOD)) ||
                    (period_cycles > PW'(MAX_PERIOD));
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        // Boundaries descend, so the first one met selects the longest-period note.
        if (!found_q && (p_q >= bnd_of(cnt_q[2:0]))) begin
          sel_d   = cnt_q[2:0];
          found_d = 1'b1;
        end
        if (cnt_q == 5'd4) begin
          cnt_d   = '0;
          state_d = SUB;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      SUB: begin
        // Sign and magnitude of REF - P, kept separately.
        neg_d   = (p_q > ref_sel);
        mag_d   = (p_q > ref_sel) ? (p_q - ref_sel) : (ref_sel - p_q);
        state_d = MUL;
      end
      MUL: begin
        // x*1000 = x*1024 - x*16 - x*8
        quo_d   = (mag_ext << 10) - (mag_ext << 4) - (mag_ext << 3);
        rem_d   = '0;
        cnt_d   = '0;
        state_d = DIV;
      end
      DIV: begin
        // Restoring divide: the dividend shifts out of quo_q's top while
        // quotient bits shift in at the bottom.
        if (trial >= divisor) begin
          rem_d = RW'(trial - divisor);
          quo_d = {quo_q[DW-2:0], 1'b1};
        end else begin
          rem_d = RW'(trial);
          quo_d = {quo_q[DW-2:0], 1'b0};
        end
        if (cnt_q == 5'd24) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      DONE: begin
        if (oor_q) begin
          note_d = 3'd7;
          num_d  = '0;
        end else begin
          note_d = sel_q;
          num_d  = neg_q ? (10'd0 - q_ext) : q_ext;
        end
        rv_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy           = busy_q;
  assign note           = note_q;
  assign num_to_display = num_q;
  assign result_valid   = rv_q;

endmodule
